bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter: BIN_W, default 14, width of binary input; legal range 14..16.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: clr  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 Port: bin  input  BIN_W  unsigned binary value to convert, sampled only on an accepted start.
REQ-005 Port: start  input  1  conversion request; single-cycle or level, only sampled in IDLE.
REQ-006 Port: busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-007 Port: done  output  1  one-cycle pulse: new digits valid this cycle.
REQ-008 Port: ovf  output  1  last converted value exceeded 9999; holds until next done.
REQ-009 Port: dig1/dig2/dig3/dig4  output  4 each  BCD thousands/hundreds/tens/units; dig1 leftmost, dig4 rightmost, wired directly to the display block's digit inputs.

Function
REQ-010 FSM states: IDLE, SHIFT, DONE; transitions IDLE->SHIFT on start=1, SHIFT->DONE after exactly BIN_W shift cycles, DONE->IDLE unconditionally.
REQ-011 Accepted start (IDLE, start=1) SHALL capture bin into a shift register and clear a 16-bit BCD scratch register and iteration counter.
REQ-012 Each SHIFT cycle SHALL apply add-3 to every scratch nibble >= 5, then left-shift {scratch, shift reg} by one bit (double dabble).
REQ-013 Iteration counter SHALL be $clog2(BIN_W+1) bits wide, count 0..BIN_W-1, and SHIFT SHALL exit when count = BIN_W-1.
REQ-014 busy SHALL be 1 in SHIFT only; done SHALL be 1 in DONE only, for exactly one cycle.
REQ-015 Latency: done SHALL assert exactly BIN_W+1 cycles after the clock edge that accepts start (15 cycles at BIN_W=14).
REQ-016 dig1..dig4 and ovf SHALL update only on entry to DONE and hold their values otherwise, including during the next conversion.
REQ-017 Over-range: ovf=1 when captured bin > 9999; scratch thousands carry beyond 9 SHALL NOT reach dig1 (handled per REQ-022).
REQ-018 start while in SHIFT or DONE SHALL be ignored; bin changes after acceptance SHALL NOT affect the result.
REQ-019 Conversion latency SHALL be identical for in-range and over-range values.

Reset
REQ-020 clr=0 SHALL immediately force IDLE, busy=0, done=0, ovf=0, dig1..dig4=4'h0, counter=0, scratch=0.
REQ-021 Reset asserted mid-conversion SHALL abort it with no done pulse; first start after release SHALL convert normally.

Configuration
REQ-022 Macro BIN_TO_BCD_SAT_EN: defined -> over-range result SHALL output digits 9,9,9,9 (saturate); undefined -> over-range SHALL output E,E,E,E (4'hE each, error display); ovf behaviour identical in both.

Structure
REQ-023 Shared package bcd_pkg SHALL hold: FSM state encoding, NUM_DIGITS=4, BCD_MAX=9999, ERR_DIGIT=4'hE, SAT_DIGIT=4'h9.
REQ-024 One combinational sub-module bcd_add3 (4-bit in, 4-bit out, +3 when >=5) SHALL be instantiated once per scratch nibble (4 instances).

Verification
REQ-025 bin=1234, 1-cycle start -> busy 14 cycles, done at cycle 15, digits 1,2,3,4, ovf=0.
REQ-026 bin=0 then bin=9999 back-to-back (start held high) -> 0,0,0,0 then 9,9,9,9; second start accepted only after DONE->IDLE.
REQ-027 bin=10000 -> ovf=1; digits E,E,E,E without macro, 9,9,9,9 with BIN_TO_BCD_SAT_EN; latency 15 cycles.
REQ-028 start pulse and bin=0042, then bin changed to 5555 and start re-pulsed at cycle 5 -> result 0,0,4,2, second start ignored, single done.
REQ-029 clr=0 at cycle 7 of conversion of 8765 -> outputs zero asynchronously, no done; after release, start with 0815 -> 0,8,1,5.
REQ-030 Exhaustive sweep bin=0..9999 vs reference model -> all digits match, ovf=0, every done exactly one cycle wide.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared definitions for the sequential binary-to-BCD converter.
//   state_t    : FSM state encoding (IDLE, SHIFT, DONE)
//   NUM_DIGITS : number of BCD digits produced
//   BCD_MAX    : largest value representable in NUM_DIGITS digits
//   ERR_DIGIT  : digit shown for every position on over-range (error display)
//   SAT_DIGIT  : digit shown for every position on over-range (saturation)
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int          NUM_DIGITS = 4;
  localparam int          BCD_MAX    = 9999;
  localparam logic [3:0]  ERR_DIGIT  = 4'hE;
  localparam logic [3:0]  SAT_DIGIT  = 4'h9;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3 -- double-dabble nibble correction.
//   d : BCD nibble before the shift
//   q : d + 3 when d >= 5, otherwise d unchanged
// After the following left shift a corrected nibble carries cleanly into the
// next decimal digit.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq -- sequential (one bit per clock) binary to 4-digit BCD
// converter using the double-dabble algorithm.
//
// Optional feature: define BIN_TO_BCD_SAT_EN to show 9,9,9,9 on over-range
// instead of the default E,E,E,E error display. ovf behaves the same either way.
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   clr       : asynchronous active-low reset
//   bin       : unsigned value to convert, captured only when start is accepted
//   start     : conversion request, sampled only while idle
//   busy      : high during the BIN_W shift cycles
//   done      : one-cycle pulse, new digits valid
//   ovf       : last converted value was above 9999, held until the next done
//   dig1..4   : thousands..units BCD digits, held between conversions
//   dbg_state : current FSM state (bcd_pkg::state_t encoding)
//
// Handshake: start is a request level; a conversion is accepted on the rising
// edge where the FSM is IDLE and start=1. Anything on start/bin at other times
// is ignored. Results are announced by done for exactly one cycle.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [BIN_W-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic [3:0]       dig4,
  output logic [1:0]       dbg_state
);

  localparam int                 CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BIN_W - 1);

`ifdef BIN_TO_BCD_SAT_EN
  localparam logic [3:0] OVR_DIGIT = SAT_DIGIT;
`else
  localparam logic [3:0] OVR_DIGIT = ERR_DIGIT;
`endif

  state_t            state;
  logic [BIN_W-1:0]  sr;
  logic [15:0]       scratch;
  logic [CNT_W-1:0]  cnt;
  logic              over;

  logic [15:0]       adj;
  logic [15:0]       scratch_nxt;
  logic [BIN_W-1:0]  sr_nxt;
  logic              bin_over;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scratch[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  // One double-dabble step: corrected scratch and shift register move left
  // together; the MSB of the shift register enters the units nibble.
  assign scratch_nxt = {adj[14:0], sr[BIN_W-1]};
  assign sr_nxt      = {sr[BIN_W-2:0], 1'b0};

  // Over-range is decided from the captured value; the 16-bit scratch
  // cannot hold a fifth decimal digit, so its top nibble is discarded then.
  assign bin_over    = ({{(32-BIN_W){1'b0}}, bin} > 32'(BCD_MAX));

  assign dbg_state   = state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= ST_IDLE;
      sr      <= '0;
      scratch <= '0;
      cnt     <= '0;
      over    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      dig1    <= 4'h0;
      dig2    <= 4'h0;
      dig3    <= 4'h0;
      dig4    <= 4'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr      <= bin;
            scratch <= '0;
            cnt     <= '0;
            over    <= bin_over;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_nxt;
          sr      <= sr_nxt;
          if (cnt == LAST) begin
            // Final shift: latch the result straight from the step logic so
            // the digits appear together with done.
            busy  <= 1'b0;
            done  <= 1'b1;
            ovf   <= over;
            dig1  <= over ? OVR_DIGIT : scratch_nxt[15:12];
            dig2  <= over ? OVR_DIGIT : scratch_nxt[11:8];
            dig3  <= over ? OVR_DIGIT : scratch_nxt[7:4];
            dig4  <= over ? OVR_DIGIT : scratch_nxt[3:0];
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq -- self-checking bench for bin_to_bcd_seq (BIN_W = 14).
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge. Expected digits come from decimal arithmetic.
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 14;
  localparam int LAT   = BIN_W + 1;

`ifdef BIN_TO_BCD_SAT_EN
  localparam logic [3:0] OVD = 4'h9;
`else
  localparam logic [3:0] OVD = 4'hE;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy, done, ovf;
  logic [3:0]       dig1, dig2, dig3, dig4;
  logic [1:0]       dbg_state;

  bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .bin       (bin),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dig1      (dig1),
    .dig2      (dig2),
    .dig3      (dig3),
    .dig4      (dig4),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] last_digits;
  logic        last_ovf;

  // reference model
  function automatic logic [15:0] ref_digits(input int v);
    if (v > 9999) return {OVD, OVD, OVD, OVD};
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] digits_now();
    return {dig1, dig2, dig3, dig4};
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one conversion with a single-cycle start; called at a falling edge
  // with the DUT idle, returns at a falling edge with the DUT idle again.
  task automatic conv(input int v, input string tag);
    logic [15:0] exp_d;
    logic        exp_o;
    int          busy_n;
    int          done_at;
    exp_d   = ref_digits(v);
    exp_o   = (v > 9999);
    bin     = BIN_W'(v);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    bin     = BIN_W'($urandom);
    check({tag, "_hold_dig"}, 32'(digits_now()), 32'(last_digits));
    check({tag, "_hold_ovf"}, 32'(ovf), 32'(last_ovf));
    busy_n  = 0;
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      if (busy) busy_n++;
      if (done) done_at = c;
      else @(negedge clk);
    end
    check({tag, "_latency"}, 32'(done_at), 32'(LAT));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(BIN_W));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_digits"}, 32'(digits_now()), 32'(exp_d));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_digits_hold"}, 32'(digits_now()), 32'(exp_d));
    last_digits = exp_d;
    last_ovf    = exp_o;
  endtask

  initial begin
    int c;
    int d1, d2, ndone, first_at;
    logic [15:0] first_d;

    // reset state
    clr   = 1'b0;
    start = 1'b0;
    bin   = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_digits", 32'(digits_now()), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    last_digits = 16'h0;
    last_ovf    = 1'b0;

    // basic conversion
    conv(1234, "c1234");

    // back-to-back with start held high: 0 then 9999
    bin   = BIN_W'(0);
    start = 1'b1;
    @(negedge clk);
    bin = BIN_W'(9999);
    c = 1; d1 = 0; d2 = 0;
    while (c <= 60 && d2 == 0) begin
      if (done) begin
        if (d1 == 0) begin
          d1 = c;
          check("b2b_first_digits", 32'(digits_now()), 32'h0000);
        end else begin
          d2 = c;
          check("b2b_second_digits", 32'(digits_now()), 32'h9999);
          start = 1'b0;
        end
      end
      if (d2 == 0) begin
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    check("b2b_first_latency", 32'(d1), 32'(LAT));
    check("b2b_second_latency", 32'(d2), 32'(2 * LAT + 1));
    @(negedge clk);
    last_digits = 16'h9999;
    last_ovf    = 1'b0;

    // over-range boundary
    conv(10000, "c10000");
    conv(16383, "cmax");

    // bin change plus re-pulsed start during SHIFT is ignored
    bin   = BIN_W'(42);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    ndone    = 0;
    first_at = 0;
    first_d  = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        bin   = BIN_W'(5555);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first_at == 0) begin
          first_at = k;
          first_d  = digits_now();
          check("ign_ovf", 32'(ovf), 32'd0);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_digits", 32'(first_d), 32'h0042);
    check("ign_latency", 32'(first_at), 32'(LAT));
    check("ign_done_count", 32'(ndone), 32'd1);
    last_digits = 16'h0042;
    last_ovf    = 1'b0;

    // reset during conversion of 8765
    bin   = BIN_W'(8765);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    clr = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_digits", 32'(digits_now()), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    clr   = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    last_digits = 16'h0;
    last_ovf    = 1'b0;
    conv(815, "c0815");

    // decimal boundaries
    conv(0, "c0");
    conv(9, "c9");
    conv(10, "c10");
    conv(99, "c99");
    conv(100, "c100");
    conv(999, "c999");
    conv(1000, "c1000");
    conv(9999, "c9999");
    conv(10001, "c10001");

    // random in-range and over-range values
    for (int k = 0; k < 200; k++) conv(int'($urandom_range(9999, 0)), "rnd");
    for (int k = 0; k < 20; k++) conv(int'($urandom_range(16383, 10000)), "rnd_ovr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
